// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, synchronous imem address issue and a
// 2-entry skid FIFO toward decode, with redirect flush and misaligned-target trap.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0004,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    output logic        imem_rw,
    output logic [31:0] imem_data_in,
    input  logic [31:0] imem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_exc_misaligned
);

    logic [31:0] pc;
    logic [31:0] addr_q;
    logic        halted;
    logic        vld_p1;
    logic [31:0] resp_pc_p1;
    logic        exc_p1;
    logic [31:0] exc_pc_p1;

    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        q_exc   [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        redirect_aligned;
    logic [31:0] issue_pc;
    logic        deq;
    logic [2:0]  occ;
    logic        issue;
    logic        enq_resp;
    logic        enq_exc;
    logic        enq;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;

    assign imem_rw      = 1'b1;
    assign imem_data_in = '0;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
    assign issue_pc         = redirect_valid ? redirect_pc : pc;
    assign deq              = if_valid && if_ready;
    // Credit counts queued entries plus the response still in the memory pipe.
    assign occ   = {1'b0, count} + {2'b00, vld_p1} - {2'b00, deq};
    assign issue = reset && (redirect_valid ? redirect_aligned : (!halted && (occ < 3'd2)));

    assign imem_address = issue ? {2'b00, issue_pc[31:2]} : addr_q;

    // A redirect in the same cycle kills whatever would have been enqueued.
    assign enq_resp  = vld_p1 && !redirect_valid;
    assign enq_exc   = exc_p1 && !redirect_valid;
    assign enq       = enq_resp || enq_exc;
    assign enq_pc    = enq_exc ? exc_pc_p1 : resp_pc_p1;
    assign enq_instr = enq_exc ? NOP_INSTR : imem_data_out;

    assign if_valid          = (count != 2'd0);
    assign if_pc             = q_pc[rd_ptr];
    assign if_instr          = q_instr[rd_ptr];
    assign if_exc_misaligned = q_exc[rd_ptr];

    // p0 -> p1: address issue and in-flight tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            addr_q     <= {2'b00, RESET_PC[31:2]};
            halted     <= 1'b0;
            vld_p1     <= 1'b0;
            resp_pc_p1 <= '0;
            exc_p1     <= 1'b0;
            exc_pc_p1  <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                addr_q     <= {2'b00, issue_pc[31:2]};
                resp_pc_p1 <= issue_pc;
                pc         <= issue_pc + 32'd4;
            end
            exc_p1 <= redirect_valid && !redirect_aligned;
            if (redirect_valid) begin
                exc_pc_p1 <= redirect_pc;
                halted    <= !redirect_aligned;
            end
        end
    end

    // p1 -> p2: skid FIFO toward decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
            q_exc[0]   <= 1'b0;
            q_exc[1]   <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) begin
                q_pc[wr_ptr]    <= enq_pc;
                q_instr[wr_ptr] <= enq_instr;
                q_exc[wr_ptr]   <= enq_exc;
                wr_ptr          <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: synchronous memory model, vector table for the cold start,
// scoreboard of expected {pc, instr, exc} entries popped on every decode accept.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_address;
    logic        imem_rw;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc_misaligned;

    instr_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .imem_address      (imem_address),
        .imem_rw           (imem_rw),
        .imem_data_in      (imem_data_in),
        .imem_data_out     (imem_data_out),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .if_ready          (if_ready),
        .if_valid          (if_valid),
        .if_pc             (if_pc),
        .if_instr          (if_instr),
        .if_exc_misaligned (if_exc_misaligned)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    always @(posedge clk) imem_data_out <= mem[imem_address[5:0]];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    ent_t sbq[$];
    ent_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pops     = 0;
    logic sb_on    = 1'b0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            sbq.push_back('{pc: p, instr: mem[p[7:2]], exc: 1'b0});
            p = p + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb_on && reset) begin
            if (prev_stall && if_valid) begin
                chk("hold_pc", if_pc, prev_pc);
                chk("hold_instr", if_instr, prev_instr);
            end
            if (if_valid && if_ready && !redirect_valid) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: unexpected pc %h, nothing expected", if_pc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_pc", if_pc, e.pc);
                    chk("sb_instr", if_instr, e.instr);
                    chk("sb_exc", {31'd0, if_exc_misaligned}, {31'd0, e.exc});
                    pops++;
                end
            end
            prev_stall <= if_valid && !if_ready && !redirect_valid;
            prev_pc    <= if_pc;
            prev_instr <= if_instr;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [7];
        logic [31:0] addr_snap;
        int          pops0;

        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + i;
        mem[1] = 32'h0010_8093;
        mem[2] = 32'h0011_0113;
        mem[3] = 32'h0020_8133;
        mem[4] = 32'h0020_80b3;
        mem[5] = 32'hffdf_f1ef;

        tbl[0] = '{1'b0, 32'h0,  32'h0};
        tbl[1] = '{1'b0, 32'h0,  32'h0};
        tbl[2] = '{1'b1, 32'h4,  32'h0010_8093};
        tbl[3] = '{1'b1, 32'h8,  32'h0011_0113};
        tbl[4] = '{1'b1, 32'hC,  32'h0020_8133};
        tbl[5] = '{1'b1, 32'h10, 32'h0020_80b3};
        tbl[6] = '{1'b1, 32'h14, 32'hffdf_f1ef};

        reset          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_exc", {31'd0, if_exc_misaligned}, 32'd0);
        chk("rst_rw", {31'd0, imem_rw}, 32'd1);
        chk("rst_addr", imem_address, 32'd1);
        chk("rst_din", imem_data_in, 32'd0);

        // Cold start, vector table
        reset    = 1'b1;
        if_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_valid", k), {31'd0, if_valid}, {31'd0, tbl[k].valid});
            if (tbl[k].valid) begin
                chk($sformatf("vec%0d_pc", k), if_pc, tbl[k].pc);
                chk($sformatf("vec%0d_instr", k), if_instr, tbl[k].instr);
            end
        end

        // Restart with scoreboard, stall after the first accept
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_valid", {31'd0, if_valid}, 32'd0);
        tick();
        reset    = 1'b1;
        if_ready = 1'b1;
        sbq.delete();
        push_seq(32'h4, 8);
        sb_on = 1'b1;
        repeat (3) tick();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_instr", if_instr, 32'h0011_0113);
            tick();
        end
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("resume_valid", {31'd0, if_valid}, 32'd1);
            tick();
        end
        if_ready = 1'b0;
        repeat (4) tick();

        // Redirect while full
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        sbq.delete();
        push_seq(32'h10, 2);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_flush_valid", {31'd0, if_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("redir_valid", {31'd0, if_valid}, 32'd1);
        chk("redir_pc", if_pc, 32'h10);
        chk("redir_instr", if_instr, 32'h0020_80b3);

        // Redirect on the edge where a response returns
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        tick();
        redirect_pc = 32'h4;
        sbq.delete();
        push_seq(32'h4, 6);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("stale_valid", {31'd0, if_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("stale_pc", if_pc, 32'h4);
        chk("stale_instr", if_instr, 32'h0010_8093);
        tick();
        if_ready = 1'b1;
        repeat (3) tick();

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        sbq.delete();
        sbq.push_back('{pc: 32'h6, instr: 32'h0000_0013, exc: 1'b1});
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("mis_flush_valid", {31'd0, if_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("mis_valid", {31'd0, if_valid}, 32'd1);
        chk("mis_pc", if_pc, 32'h6);
        chk("mis_instr", if_instr, 32'h0000_0013);
        chk("mis_exc", {31'd0, if_exc_misaligned}, 32'd1);
        addr_snap = imem_address;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("halt_valid", {31'd0, if_valid}, 32'd0);
            chk("halt_addr", imem_address, addr_snap);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        sbq.delete();
        push_seq(32'h4, 6);
        tick();
        redirect_valid = 1'b0;
        pops0 = pops;
        repeat (4) tick();
        chk("resume_pops", pops - pops0, 3);

        // Reset mid-stall with two entries queued
        if_ready = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, if_valid}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_pc", if_pc, 32'd0);
        chk("mid_rst_addr", imem_address, 32'd1);
        sbq.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rst_rw", {31'd0, imem_rw}, 32'd1);
            tick();
        end
        reset    = 1'b1;
        if_ready = 1'b1;
        push_seq(32'h4, 6);
        pops0 = pops;
        repeat (5) tick();
        sb_on = 1'b0;
        chk("restart_pops", pops - pops0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
